// File: rtl/pt_pkg.sv
// Shared constants, encodings and types for the pulse-train decoder.
package pt_pkg;

    localparam logic [6:0] SHORT_MIN = 7'd2;
    localparam logic [6:0] SHORT_MAX = 7'd6;
    localparam logic [6:0] LONG_MIN  = 7'd10;
    localparam logic [6:0] LONG_MAX  = 7'd14;
    localparam logic [6:0] SYNC_GAP  = 7'd64;
    localparam logic [6:0] RUN_MAX   = 7'd127;

    localparam int unsigned CB_PER_FRAME = 12;
    localparam logic [5:0]  LAST_PHASE   = 6'(4 * CB_PER_FRAME - 1);

    localparam logic [1:0] CB_ZERO  = 2'b00;
    localparam logic [1:0] CB_ONE   = 2'b01;
    localparam logic [1:0] CB_FLOAT = 2'b10;

    typedef enum logic [1:0] {StHunt, StData, StSyncHi, StSyncLo} pt_state_e;

    typedef enum logic [1:0] {ClsBad, ClsShort, ClsLong} run_cls_e;

    function automatic run_cls_e classify(input logic [6:0] len);
        if (len >= SHORT_MIN && len <= SHORT_MAX) begin
            return ClsShort;
        end
        if (len >= LONG_MIN && len <= LONG_MAX) begin
            return ClsLong;
        end
        return ClsBad;
    endfunction

endpackage

// File: rtl/pt_run_meas.sv
// Synchronizes the serial line and measures/classifies each constant-level run.
module pt_run_meas
    import pt_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     d,
    output logic     closed,
    output logic     closed_lvl,
    output run_cls_e closed_cls,
    output logic     gap_eq,
    output logic     gap_ge
);

    logic       sync1_q, ds_q, ds_last_q;
    logic [1:0] prime_q;
    logic [6:0] run_cnt_q, run_cnt_d;
    logic       live, edge_det, low_cont;

    // Runs are only counted once real line samples have reached ds after reset.
    assign live     = prime_q[1];
    assign edge_det = live && (ds_q != ds_last_q);
    assign low_cont = live && !ds_q && !edge_det;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (edge_det) begin
            run_cnt_d = 7'd1;
        end else if (live && run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            ds_q      <= 1'b0;
            ds_last_q <= 1'b0;
            prime_q   <= 2'b00;
            run_cnt_q <= 7'd0;
        end else begin
            sync1_q   <= d;
            ds_q      <= sync1_q;
            ds_last_q <= ds_q;
            prime_q   <= {prime_q[0], 1'b1};
            run_cnt_q <= run_cnt_d;
        end
    end

    // run_cnt_q excludes the current cycle, so 63 here means the low run is now 64 long.
    assign closed     = edge_det;
    assign closed_lvl = ds_last_q;
    assign closed_cls = classify(run_cnt_q);
    assign gap_eq     = low_cont && (run_cnt_q == SYNC_GAP - 7'd1);
    assign gap_ge     = low_cont && (run_cnt_q >= SYNC_GAP - 7'd1);

endmodule

// File: rtl/pt_dec.sv
// Pulse-train frame decoder: phase/codebit FSM and shift registers over pt_run_meas.
module pt_dec
    import pt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        d,
    output logic [23:0] ad,
    output logic        valid,
    output logic        err
);

    logic      closed, closed_lvl, gap_eq, gap_ge;
    run_cls_e  closed_cls;

    pt_state_e   state_q, state_d;
    logic [5:0]  phase_q, phase_d;
    logic [23:0] shadow_q, shadow_d, ad_q, ad_d;
    logic        half_q, half_d, valid_q, valid_d, err_q, err_d;
    run_cls_e    hi_cls_q, hi_cls_d;

    logic       bad, half_ok, half_val, cb_ok;
    logic [1:0] cb;

    pt_run_meas u_run_meas (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .closed     (closed),
        .closed_lvl (closed_lvl),
        .closed_cls (closed_cls),
        .gap_eq     (gap_eq),
        .gap_ge     (gap_ge)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        half_d   = half_q;
        hi_cls_d = hi_cls_q;
        ad_d     = ad_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        bad      = 1'b0;

        half_val = (hi_cls_q == ClsLong);
        half_ok  = (hi_cls_q == ClsShort && closed_cls == ClsLong) ||
                   (hi_cls_q == ClsLong  && closed_cls == ClsShort);
        cb_ok    = 1'b1;
        cb       = CB_ZERO;
        case ({half_q, half_val})
            2'b00:   cb = CB_ZERO;
            2'b11:   cb = CB_ONE;
            2'b01:   cb = CB_FLOAT;
            default: cb_ok = 1'b0;
        endcase

        case (state_q)
            StHunt: begin
                if (gap_ge) begin
                    state_d  = StData;
                    phase_d  = 6'd0;
                    shadow_d = 24'd0;
                end
            end
            StData: begin
                // At phase 0 a closing low run is the arming gap itself.
                if (gap_eq && phase_q != 6'd0) begin
                    bad = 1'b1;
                end else if (closed && (closed_lvl || phase_q != 6'd0)) begin
                    if (closed_cls == ClsBad) begin
                        bad = 1'b1;
                    end else if (!phase_q[0]) begin
                        hi_cls_d = closed_cls;
                    end else if (!half_ok) begin
                        bad = 1'b1;
                    end else if (!phase_q[1]) begin
                        half_d = half_val;
                    end else if (!cb_ok) begin
                        bad = 1'b1;
                    end else begin
                        shadow_d = {shadow_q[21:0], cb};
                    end
                    if (!bad) begin
                        if (phase_q == LAST_PHASE) begin
                            state_d = StSyncHi;
                            phase_d = 6'd0;
                        end else begin
                            phase_d = phase_q + 6'd1;
                        end
                    end
                end
            end
            StSyncHi: begin
                if (closed) begin
                    if (closed_lvl && closed_cls == ClsShort) begin
                        state_d = StSyncLo;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            StSyncLo: begin
                if (gap_eq) begin
                    ad_d     = shadow_q;
                    valid_d  = 1'b1;
                    state_d  = StData;
                    phase_d  = 6'd0;
                    shadow_d = 24'd0;
                end else if (closed) begin
                    bad = 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase

        if (bad) begin
            err_d    = 1'b1;
            state_d  = StHunt;
            phase_d  = 6'd0;
            shadow_d = 24'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StHunt;
            phase_q  <= 6'd0;
            shadow_q <= 24'd0;
            half_q   <= 1'b0;
            hi_cls_q <= ClsBad;
            ad_q     <= 24'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            half_q   <= half_d;
            hi_cls_q <= hi_cls_d;
            ad_q     <= ad_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ad    = ad_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_pt_dec.sv
// Directed bench for pt_dec: encoder-style frames, malformed pulses, short gaps, resets.
module tb_pt_dec;

    localparam int S   = 4;
    localparam int L   = 12;
    localparam int GAP = 70;

    logic        clk = 1'b0;
    logic        rst;
    logic        d;
    logic [23:0] ad;
    logic        valid;
    logic        err;

    pt_dec dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .ad    (ad),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc       = 0;
    int fall_cyc  = 0;
    int valid_cyc = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int n_checks  = 0;
    int n_errs    = 0;
    logic [23:0] ad_log [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            ad_log[valid_cnt[4:0]] <= ad;
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (valid && err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_run(input logic lvl, input int n);
        d = lvl;
        repeat (n) @(negedge clk);
    endtask

    // bad_cb encodes that codebit as h1h0; rst_at pulses rst before that phase;
    // stop_at abandons the frame before that phase.
    task automatic send_frame(input logic [23:0] w, input int hi0, input int bad_cb,
                              input int rst_at, input int stop_at, input int gap);
        int         runs [48];
        logic [1:0] cb;
        logic       h1, h2;
        for (int i = 0; i < 12; i++) begin
            cb = w[23-2*i -: 2];
            if (i == bad_cb) begin
                h1 = 1'b1;
                h2 = 1'b0;
            end else begin
                h1 = cb[0];
                h2 = cb[0] | cb[1];
            end
            runs[4*i]   = h1 ? L : S;
            runs[4*i+1] = h1 ? S : L;
            runs[4*i+2] = h2 ? L : S;
            runs[4*i+3] = h2 ? S : L;
        end
        if (hi0 > 0) runs[0] = hi0;
        for (int p = 0; p < 48; p++) begin
            if (p == stop_at) return;
            if (p == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            send_run((p % 2) == 0, runs[p]);
        end
        send_run(1'b1, S);
        fall_cyc = cyc;
        send_run(1'b0, gap);
    endtask

    logic [23:0] d_words [4];
    int          d_pulse [4];
    int          v0, e0;

    initial begin
        d_words[0] = 24'h1A6A1A; d_pulse[0] = 2;
        d_words[1] = 24'h5A65A6; d_pulse[1] = 10;
        d_words[2] = 24'h249249; d_pulse[2] = 6;
        d_words[3] = 24'h555555; d_pulse[3] = 14;

        rst = 1'b1;
        d   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ad", ad, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // 63-clk gap from reset must not arm
        send_run(1'b0, 63);
        send_frame(24'h249249, 0, -1, -1, 48, GAP);
        check("gap63_novalid", valid_cnt, 0);
        check("gap63_noerr", err_cnt, 0);

        send_frame(24'h249249, 0, -1, -1, 48, GAP);
        check("loop_valid", valid_cnt, 1);
        check("loop_ad", ad, 24'h249249);
        check("loop_err", err_cnt, 0);
        check("latency", valid_cyc - fall_cyc, 66);

        // back-to-back with minimum gap
        send_frame(24'h000000, 0, -1, -1, 48, 64);
        send_frame(24'h555555, 0, -1, -1, 48, GAP);
        check("b2b_cnt", valid_cnt, 3);
        check("b2b_ad0", ad_log[1], 24'h000000);
        check("b2b_ad1", ad_log[2], 24'h555555);

        // h1h0 at codebit 3
        send_frame(24'h1A6A1A, 0, 3, -1, 48, GAP);
        check("h1h0_err", err_cnt, 1);
        check("h1h0_novalid", valid_cnt, 3);
        check("h1h0_adhold", ad, 24'h555555);
        send_frame(24'h249249, 0, -1, -1, 48, GAP);
        check("after_h1h0_ad", ad, 24'h249249);
        check("after_h1h0_cnt", valid_cnt, 4);

        // 8-clk high pulse is neither S nor L
        send_frame(24'h1A6A1A, 8, -1, -1, 48, GAP);
        check("pulse8_err", err_cnt, 2);
        check("pulse8_novalid", valid_cnt, 4);
        for (int k = 0; k < 4; k++) begin
            send_frame(d_words[k], d_pulse[k], -1, -1, 48, GAP);
            check("pulse_ok_ad", ad, d_words[k]);
            check("pulse_ok_cnt", valid_cnt, 5 + k);
        end
        check("pulse_ok_err", err_cnt, 2);

        // reset at phase 20
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(24'h2A1964, 0, -1, 20, 48, GAP);
        check("midrst_ad", ad, 0);
        check("midrst_valid", valid_cnt, v0);
        check("midrst_err", err_cnt, e0);
        send_frame(24'h2A1964, 0, -1, -1, 48, GAP);
        check("midrst_next_ad", ad, 24'h2A1964);
        check("midrst_next_cnt", valid_cnt, v0 + 1);

        // line stalls low mid-frame, then re-arms on the same gap
        send_frame(24'h5A65A6, 0, -1, -1, 10, 0);
        send_run(1'b0, GAP);
        check("stall_err", err_cnt, e0 + 1);
        check("stall_novalid", valid_cnt, v0 + 1);
        send_frame(24'h1A6A1A, 0, -1, -1, 48, GAP);
        check("stall_next_ad", ad, 24'h1A6A1A);
        check("stall_next_cnt", valid_cnt, v0 + 2);

        check("valid_err_excl", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
